// File: rtl/nios_system_pio_pkg.sv
// Shared constants and bus request type for the edge-capturing PIO input port.
package nios_system_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_RSVD = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/nios_system_pio_sync.sv
// Multi-stage input synchroniser with previous-sample register and per-bit edge detect.
module nios_system_pio_sync
   import nios_system_pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 10,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] sync_q,
   output logic [DATA_WIDTH-1:0] edge_det
);

   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stage_q, stage_d;
   logic [DATA_WIDTH-1:0]                  prev_q, prev_d;

   always_comb begin
      stage_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) stage_d[i] = stage_q[i-1];
      prev_d = stage_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= '0;
         prev_q  <= '0;
      end else begin
         stage_q <= stage_d;
         prev_q  <= prev_d;
      end
   end

   assign sync_q = stage_q[SYNC_STAGES-1];

   always_comb begin
      edge_det = sync_q & ~prev_q;
      if (EDGE_TYPE == EDGE_FALLING) edge_det = ~sync_q & prev_q;
      else if (EDGE_TYPE == EDGE_ANY) edge_det = sync_q ^ prev_q;
   end

endmodule

// File: rtl/nios_system_pio_capture.sv
// Avalon-MM input port: synchronised data, sticky edge capture with W1C, mask and level irq.
module nios_system_pio_capture
   import nios_system_pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 10,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

   bus_req_t              req;
   logic [DATA_WIDTH-1:0] sync_q, edge_det;
   logic [DATA_WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, clr_mask;
   logic [2:0]            warm_q, warm_d;
   logic [31:0]           rd_q, rd_d;
   logic                  warm_done;

   assign req = '{wr: chipselect & ~write_n, addr: address, wdata: writedata};

   generate
      if (DATA_WIDTH < 32) begin : g_unused_wd
         logic unused_wd;
         assign unused_wd = ^writedata[31:DATA_WIDTH];
      end
   endgenerate

   nios_system_pio_sync #(
      .DATA_WIDTH (DATA_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .sync_q  (sync_q),
      .edge_det(edge_det)
   );

   // Edges are ignored until the chain and prev register hold real samples.
   assign warm_done = (warm_q == WARM_MAX);

   always_comb begin
      warm_d   = warm_done ? warm_q : warm_q + 3'd1;
      mask_d   = mask_q;
      clr_mask = '0;
      if (req.wr && req.addr == ADDR_MASK) mask_d = req.wdata[DATA_WIDTH-1:0];
      if (req.wr && req.addr == ADDR_EDGE) clr_mask = req.wdata[DATA_WIDTH-1:0];
      cap_d = (cap_q & ~clr_mask) | (warm_done ? edge_det : '0);
      case (req.addr)
         ADDR_DATA: rd_d = 32'(sync_q);
         ADDR_MASK: rd_d = 32'(mask_q);
         ADDR_EDGE: rd_d = 32'(cap_q);
         default:   rd_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         warm_q <= '0;
         mask_q <= '0;
         cap_q  <= '0;
         rd_q   <= '0;
      end else begin
         warm_q <= warm_d;
         mask_q <= mask_d;
         cap_q  <= cap_d;
         rd_q   <= rd_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/nios_system_pio_capture.md
# nios_system_pio_capture

Parametrised Avalon-MM slave input port for the Nios II system: samples a DATA_WIDTH-bit external bus through a multi-stage synchroniser and detects per-bit edges into a sticky edge-capture register. It raises a level interrupt when any captured edge is unmasked. It sits on the Nios data master beside the existing plain input ports and serves pixel/coordinate and button inputs that must not be lost between polls.

## Interface
- DATA_WIDTH, 10: width of in_port and of every internal register; legal 1..32.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: synchroniser flops per bit; legal 2..4.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select; qualifies writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above DATA_WIDTH are ignored.
- in_port  in  DATA_WIDTH  asynchronous external input bus.
- readdata  out  32  registered read data; bits above DATA_WIDTH are 0.
- irq  out  1  level interrupt to the Nios IRQ controller.

## Operation
- Register map (word addresses):
  - 0 DATA: synchronised input, read-only.
  - 1 IRQ_MASK: RW, 1 = enable that bit.
  - 2 reserved: reads 0, writes ignored.
  - 3 EDGE_CAPTURE: read; write-1-to-clear per bit.
- Write: occurs when chipselect=1 and write_n=0 at a clk edge.
  - Address 1 loads mask <= writedata[DATA_WIDTH-1:0].
  - Address 3 clears each capture bit where writedata bit is 1.
- Read path has no read strobe. readdata <= mux(address) every cycle and reflects register state before that edge's updates.
- Synchroniser: SYNC_STAGES flops per bit. sync_q is the last stage. prev_q <= sync_q every cycle.
- Edge detect per bit:
  - rising = sync_q & ~prev_q.
  - falling = ~sync_q & prev_q.
  - any = sync_q ^ prev_q.
- Warm-up counter:
  - Counts 0..SYNC_STAGES+1 after reset, then saturates.
  - Edge detection is gated off until saturated, so reset-time levels never produce spurious captures.
- Capture update: cap <= (cap & ~clr_mask) | edge. Set wins over clear when an edge and a W1C on the same bit coincide in one cycle.
- irq = |(cap & mask). It is driven only from registers, so it is glitch-free.
- Mask does not gate capture. Unmasking a bit with a captured edge asserts irq on the next cycle.

## Timing
- Reset values: readdata 0, irq 0, mask 0, cap 0, sync/prev flops 0, warm-up counter 0.
- Reset assertion mid-operation clears all state immediately (asynchronously). Warm-up restarts on deassertion.
- in_port change sampled at edge k:
  - sync_q updates at edge k+SYNC_STAGES-1.
  - DATA readdata shows it at edge k+SYNC_STAGES.
- Edge capture bit sets at edge k+SYNC_STAGES. irq rises in the same cycle if the bit is masked in.
- Read latency: 1 cycle from address to readdata.
- W1C at edge j: cap bit is 0 after edge j. irq falls after edge j if no other unmasked bit is set.
- Mask write at edge j: irq reflects the new mask after edge j.
- A pulse shorter than one clk period may be missed. Pulses of at least 2 clk periods are always captured.

## Structure
- Package nios_system_pio_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=3.
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
- Sub-module nios_system_pio_sync, parametrised by DATA_WIDTH/SYNC_STAGES/EDGE_TYPE:
  - Contains the synchroniser, prev register and edge-detect logic.
  - Outputs sync_q and the edge vector.
  - Top level holds the warm-up counter, mask, capture, read mux and irq.

## Test plan
- Reset with in_port=10'h3FF held, EDGE_TYPE=0 -> after 10 cycles cap=0, irq=0, DATA read returns 0x3FF.
- Rising edge: mask=0x001, bit0 driven 0→1 at edge k -> cap[0]=1 and irq=1 at edge k+2 (SYNC_STAGES=2). Reads of address 3 return 0x001.
- W1C write 0x001 to address 3 -> irq=0 next cycle. W1C coinciding with a new edge on bit0 -> cap[0] stays 1.
- Masking: edge on bit5 with mask=0 -> cap=0x020, irq=0. Then write mask=0x020 -> irq=1 one cycle later.
- EDGE_TYPE=1 and 2 builds: bit3 driven 1→0 -> captured in both. Bit3 driven 0→1 -> captured only with EDGE_TYPE=2.
- Address 2 read returns 0. DATA_WIDTH=32 build with in_port=0xDEADBEEF -> readdata=0xDEADBEEF. Async reset asserted mid-capture -> all outputs 0 immediately.
